// File: rtl/baud_tick_counter.sv
// baud_tick_counter: programmable-period tick generator with free-running and one-shot modes.
// Define BAUD_TICK_COUNTER_HALF_EN to build the mid-period half pulse; otherwise half is tied low.
module baud_tick_counter #(
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 867,
    parameter bit AUTOSTART      = 1'b1
) (
    input  logic             in,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] period,
    output logic             out,
    output logic             half,
    output logic             busy,
    output logic [WIDTH-1:0] count
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] count_n, period_q, period_n;
    logic out_n, act, wrap;
    assign act  = (state == RUN) && en;
    // >= rather than == so a shrunken period_q still wraps at once
    assign wrap = count >= period_q;
    assign busy = state == RUN;
    always_comb begin
        state_n  = state;
        count_n  = count;
        period_n = period_q;
        out_n    = 1'b0;
        if (start) begin
            state_n  = RUN;
            count_n  = '0;
            period_n = period;
        end else if (act) begin
            count_n = wrap ? '0 : count + 1'b1;
            out_n   = wrap;
            if (wrap) begin
                period_n = period;
                state_n  = oneshot ? IDLE : RUN;
            end
        end
    end
    always_ff @(posedge in or posedge rst)
        if (rst) begin
            state    <= AUTOSTART ? RUN : IDLE;
            count    <= '0;
            period_q <= WIDTH'(DEFAULT_PERIOD);
            out      <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            period_q <= period_n;
            out      <= out_n;
        end
`ifdef BAUD_TICK_COUNTER_HALF_EN
    logic half_n;
    assign half_n = !start && act && !wrap && (count == (period_q >> 1));
    always_ff @(posedge in or posedge rst)
        if (rst) half <= 1'b0;
        else     half <= half_n;
`else
    assign half = 1'b0;
`endif
endmodule

// File: tb/tb_baud_tick_counter.sv
// tb_baud_tick_counter: directed and random stimulus against a cycle-level reference model
// for one auto-starting and one idle-at-reset instance.
module tb_baud_tick_counter;
    localparam int W = 8;
    localparam int DP0 = 3;
    localparam int DP1 = 5;
`ifdef BAUD_TICK_COUNTER_HALF_EN
    localparam bit HALF_ON = 1'b1;
`else
    localparam bit HALF_ON = 1'b0;
`endif
    logic in = 1'b0;
    logic rst, en, oneshot;
    logic [1:0] start;
    logic [W-1:0] period;
    logic [1:0] out, half, busy;
    logic [W-1:0] count [2];
    int total = 0, passed = 0;
    int m_run [2], m_cnt [2], m_pq [2], m_out [2], m_half [2];

    baud_tick_counter #(.WIDTH(W), .DEFAULT_PERIOD(DP0), .AUTOSTART(1'b1)) u0 (
        .in(in), .rst(rst), .en(en), .start(start[0]), .oneshot(oneshot), .period(period),
        .out(out[0]), .half(half[0]), .busy(busy[0]), .count(count[0]));
    baud_tick_counter #(.WIDTH(W), .DEFAULT_PERIOD(DP1), .AUTOSTART(1'b0)) u1 (
        .in(in), .rst(rst), .en(en), .start(start[1]), .oneshot(oneshot), .period(period),
        .out(out[1]), .half(half[1]), .busy(busy[1]), .count(count[1]));

    always #5 in = ~in;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_run = '{1, 0};
        m_cnt = '{0, 0};
        m_pq = '{DP0, DP1};
        m_out = '{0, 0};
        m_half = '{0, 0};
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s u%0d out", tag, i), int'(out[i]), m_out[i]);
            check($sformatf("%s u%0d half", tag, i), int'(half[i]), HALF_ON ? m_half[i] : 0);
            check($sformatf("%s u%0d busy", tag, i), int'(busy[i]), m_run[i]);
            check($sformatf("%s u%0d count", tag, i), int'(count[i]), m_cnt[i]);
        end
    endtask

    // Tick period is pq+1 enabled cycles; half marks the centre count pq/2 when pq > 0.
    task automatic cyc(input string tag);
        @(posedge in);
        for (int i = 0; i < 2; i++) begin
            if (start[i]) begin
                m_run[i] = 1; m_cnt[i] = 0; m_pq[i] = int'(period); m_out[i] = 0; m_half[i] = 0;
            end else if (m_run[i] == 1 && en) begin
                m_half[i] = (m_cnt[i] == m_pq[i] / 2 && m_cnt[i] < m_pq[i]) ? 1 : 0;
                if (m_cnt[i] >= m_pq[i]) begin
                    m_cnt[i] = 0; m_out[i] = 1; m_pq[i] = int'(period);
                    if (oneshot) m_run[i] = 0;
                end else begin
                    m_cnt[i]++; m_out[i] = 0;
                end
            end else begin
                m_out[i] = 0; m_half[i] = 0;
            end
        end
        #1 check_all(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) cyc(tag);
    endtask

    initial begin
        int found;
        rst = 1'b1; en = 1'b0; start = 2'b00; oneshot = 1'b0; period = W'(DP0);
        model_reset();
        #2 check_all("reset");
        #10 rst = 1'b0;
        en = 1'b1;
        run("default_period", 16);
        period = 8'd9; oneshot = 1'b1; start = 2'b10;
        cyc("oneshot_start");
        start = 2'b00;
        run("oneshot", 14);
        oneshot = 1'b0; period = 8'd5; start = 2'b11;
        cyc("free5_start");
        start = 2'b00;
        run("free5", 3);
        period = 8'd2;
        run("period_change", 12);
        period = 8'd7; start = 2'b11;
        cyc("en_start");
        start = 2'b00;
        run("en_pre", 3);
        en = 1'b0;
        run("en_low", 4);
        en = 1'b1;
        run("en_post", 12);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (m_cnt[0] == m_pq[0]) found = 1;
            else cyc("seek_wrap");
        end
        check("wrap_found", found, 1);
        start = 2'b01;
        cyc("start_on_wrap");
        check("start_on_wrap no out", int'(out[0]), 0);
        start = 2'b00;
        run("after_restart", 9);
        period = 8'd0; start = 2'b11;
        cyc("p0_start");
        start = 2'b00;
        run("period0", 4);
        period = 8'd1; start = 2'b11;
        cyc("p1_start");
        start = 2'b00;
        run("period1", 6);
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b00;
            oneshot = ($urandom_range(0, 7) == 0);
            period = 8'($urandom_range(0, 6));
            cyc("random");
        end
        start = 2'b00; oneshot = 1'b0; en = 1'b1; period = 8'd6; start = 2'b11;
        cyc("pre_rst_start");
        start = 2'b00;
        run("pre_rst", 3);
        #3 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        #3 rst = 1'b0;
        period = 8'd3;
        run("post_rst", 6);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
